// File: rtl/seg7_scan_driver_if.sv
// Host-side bundle for seg7_scan_driver: load handshake, value/format inputs,
// status flags and the multiplexed display outputs.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14
);
  logic                  load;
  logic [VAL_W-1:0]      value;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  blank_lz;
  logic                  busy;
  logic                  overflow;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;

  modport master (
    output load, value, dp_in, blank_lz,
    input  busy, overflow, an, seg, dp
  );

  modport slave (
    input  load, value, dp_in, blank_lz,
    output busy, overflow, an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD (sequential double dabble) plus tick-driven digit scan for a
// common-anode 7-segment display with leading-zero blanking and overflow dashes.
//
// state  | meaning
// IDLE   | waiting for load; display regs stable
// CONV   | VAL_W double-dabble iterations, down-counter marks the last one
// UPDT   | commit BCD, dp, blank mode and overflow to the display regs
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          tick,
  seg7_scan_driver_if.slave bus
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int SW = BW + VAL_W;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam logic [31:0] LIMIT = 32'(10 ** NUM_DIGITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_UPDT = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [SW-1:0]         sreg;
  logic [SW-1:0]         sreg_adj;
  logic [NUM_DIGITS-1:0] dp_pend;
  logic [NUM_DIGITS-1:0] dp_reg;
  logic                  blz_pend;
  logic                  blz_reg;
  logic                  ovf_pend;
  logic                  ovf_reg;
  logic [BW-1:0]         disp;

  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_above;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] an_r;
  logic [6:0]            seg_r;
  logic                  dp_r;

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 7'h40;
      4'd1:    font = 7'h79;
      4'd2:    font = 7'h24;
      4'd3:    font = 7'h30;
      4'd4:    font = 7'h19;
      4'd5:    font = 7'h12;
      4'd6:    font = 7'h02;
      4'd7:    font = 7'h78;
      4'd8:    font = 7'h00;
      4'd9:    font = 7'h10;
      default: font = 7'h7F;
    endcase
  endfunction

  always_comb begin
    sreg_adj = sreg;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sreg[VAL_W+4*i +: 4] >= 4'd5)
        sreg_adj[VAL_W+4*i +: 4] = sreg[VAL_W+4*i +: 4] + 4'd3;
    end
  end

  // dp and blank mode are staged with the conversion so they switch together with the digits
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sreg     <= '0;
      dp_pend  <= '0;
      dp_reg   <= '0;
      blz_pend <= 1'b0;
      blz_reg  <= 1'b0;
      ovf_pend <= 1'b0;
      ovf_reg  <= 1'b0;
      disp     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.load) begin
            state    <= S_CONV;
            sreg     <= {{BW{1'b0}}, bus.value};
            cnt      <= CW'(VAL_W - 1);
            dp_pend  <= bus.dp_in;
            blz_pend <= bus.blank_lz;
            ovf_pend <= (32'(bus.value) >= LIMIT);
          end
        end
        S_CONV: begin
          sreg <= {sreg_adj[SW-2:0], 1'b0};
          if (cnt == '0) state <= S_UPDT;
          else           cnt   <= cnt - 1'b1;
        end
        S_UPDT: begin
          disp    <= sreg[SW-1 -: BW];
          dp_reg  <= dp_pend;
          blz_reg <= blz_pend;
          ovf_reg <= ovf_pend;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (disp[4*i +: 4] == 4'd0);
      blank[i]   = blz_reg & zero_above;
    end
  end

  always_comb begin
    idx_nxt   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    cur_digit = disp[3:0];
    cur_dp    = dp_reg[0];
    cur_blank = blank[0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        cur_digit = disp[4*i +: 4];
        cur_dp    = dp_reg[i];
        cur_blank = blank[i];
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      idx   <= '0;
      an_r  <= '1;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else if (tick) begin
      idx   <= idx_nxt;
      an_r  <= ~(NUM_DIGITS'(1) << idx_nxt);
      seg_r <= ovf_reg ? 7'h3F : (cur_blank ? 7'h7F : font(cur_digit));
      dp_r  <= ovf_reg ? 1'b1 : ~cur_dp;
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.overflow = ovf_reg;
  assign bus.an       = an_r;
  assign bus.seg      = seg_r;
  assign bus.dp       = dp_r;
endmodule
